// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fixed CPU priority with a starvation guard that forces a DMA grant
// after STARVE consecutive contested CPU wins. All memory-side outputs are registered.
module mem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wd,
  output logic [DW-1:0] dma_rd,
  output logic          dma_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  input  logic          mem_ready
);

  typedef enum logic [2:0] {StIdle, StGntCpu, StGntDma, StAckCpu, StAckDma} state_e;

  state_e        state_q;
  logic [3:0]    starve_cnt_q;
  logic          mem_req_q, mem_we_q, cpu_ack_q, dma_ack_q;
  logic [AW-1:0] mem_adr_q;
  logic [DW-1:0] mem_wd_q, cpu_rd_q, dma_rd_q;
  logic          dma_wins;

  assign dma_wins  = dma_req & (~cpu_req | (starve_cnt_q == 4'(STARVE)));
  assign cpu_stall = cpu_req & ~cpu_ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_adr_q    <= '0;
      mem_wd_q     <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rd_q     <= '0;
      dma_rd_q     <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dma_wins) begin
            state_q      <= StGntDma;
            mem_req_q    <= 1'b1;
            mem_we_q     <= dma_we;
            mem_adr_q    <= dma_adr;
            mem_wd_q     <= dma_wd;
            starve_cnt_q <= 4'd0;
          end else if (cpu_req) begin
            state_q   <= StGntCpu;
            mem_req_q <= 1'b1;
            mem_we_q  <= cpu_we;
            mem_adr_q <= cpu_adr;
            mem_wd_q  <= cpu_wd;
            // Only contested CPU wins count toward forcing a DMA grant.
            if (!dma_req) begin
              starve_cnt_q <= 4'd0;
            end else if (starve_cnt_q != 4'(STARVE)) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else begin
            starve_cnt_q <= 4'd0;
          end
        end
        StGntCpu: begin
          if (mem_ready) begin
            cpu_rd_q  <= mem_rd;
            mem_req_q <= 1'b0;
            cpu_ack_q <= 1'b1;
            state_q   <= StAckCpu;
          end
        end
        StGntDma: begin
          if (mem_ready) begin
            dma_rd_q  <= mem_rd;
            mem_req_q <= 1'b0;
            dma_ack_q <= 1'b1;
            state_q   <= StAckDma;
          end
        end
        StAckCpu: state_q <= StIdle;
        StAckDma: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign mem_adr = mem_adr_q;
  assign mem_wd  = mem_wd_q;
  assign cpu_ack = cpu_ack_q;
  assign dma_ack = dma_ack_q;
  assign cpu_rd  = cpu_rd_q;
  assign dma_rd  = dma_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a wait-state memory responder plus per-scenario tasks that
// log outputs cycle by cycle and compare them against hand-computed timelines.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_adr, dma_adr, mem_adr;
  logic [DW-1:0] cpu_wd, dma_wd, cpu_rd, dma_rd, mem_wd, mem_rd;
  logic          cpu_ack, cpu_stall, dma_ack, mem_req, mem_we, mem_ready;

  int          total = 0;
  int          bad = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] rdata_cfg = '0;

  logic          mreq_l[NL], mwe_l[NL], cack_l[NL], dack_l[NL], stall_l[NL];
  logic [AW-1:0] madr_l[NL];
  logic [DW-1:0] mwd_l[NL], crd_l[NL], drd_l[NL];
  logic [3:0]    sc_l[NL];

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: ready after wait_cfg stall cycles of a continuous mem_req.
  assign mem_ready = mem_req && (wcnt == wait_cfg);
  assign mem_rd    = rdata_cfg;
  always @(posedge clk) wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_adr = '0; dma_wd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  // Logs n cycles starting with the cycle whose inputs were just set; drops requests after acks.
  task automatic watch(input int n, input bit keep_cpu, input bit tog);
    for (int k = 0; k < n; k++) begin
      if (tog) dma_adr = k[0] ? 32'h500 : 32'h504;
      #1;
      mreq_l[k] = mem_req; mwe_l[k] = mem_we; madr_l[k] = mem_adr; mwd_l[k] = mem_wd;
      cack_l[k] = cpu_ack; dack_l[k] = dma_ack; crd_l[k] = cpu_rd; drd_l[k] = dma_rd;
      stall_l[k] = cpu_stall; sc_l[k] = dut.starve_cnt_q;
      @(posedge clk); #1;
      if (cack_l[k] && !keep_cpu) cpu_req = 0;
      if (dack_l[k]) dma_req = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    total++; if ({mem_req, mem_we, cpu_ack, dma_ack} !== 4'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {mem_req, mem_we, cpu_ack, dma_ack}); end
    total++; if (mem_adr !== '0 || mem_wd !== '0) begin bad++;
      $display("FAIL reset_mem adr=%h wd=%h want 0", mem_adr, mem_wd); end
    total++; if (cpu_rd !== '0 || dma_rd !== '0) begin bad++;
      $display("FAIL reset_rd cpu=%h dma=%h want 0", cpu_rd, dma_rd); end
    total++; if (cpu_stall !== 1'b0 || dut.starve_cnt_q !== 4'd0) begin bad++;
      $display("FAIL reset_misc stall=%b cnt=%0d want 0", cpu_stall, dut.starve_cnt_q); end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read();
    int nreq = 0, nstall = 0, ack_at = -1, attr_bad = 0;
    wait_cfg = 0; rdata_cfg = 32'hDEADBEEF;
    cpu_we = 0; cpu_adr = 32'h20; cpu_req = 1;
    watch(6, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (mreq_l[k]) begin
        nreq++;
        if (madr_l[k] !== 32'h20 || mwe_l[k] !== 1'b0) attr_bad++;
      end
      if (stall_l[k]) nstall++;
      if (cack_l[k] && ack_at < 0) ack_at = k;
    end
    total++; if (nreq !== 1 || mreq_l[1] !== 1'b1) begin bad++;
      $display("FAIL cpu_rd_memreq cycles=%0d want=1 at cycle 1", nreq); end
    total++; if (attr_bad !== 0) begin bad++;
      $display("FAIL cpu_rd_attr bad_cycles=%0d want=0", attr_bad); end
    total++; if (ack_at !== 2) begin bad++;
      $display("FAIL cpu_rd_ack_cycle got=%0d want=2", ack_at); end
    total++; if (crd_l[2] !== 32'hDEADBEEF) begin bad++;
      $display("FAIL cpu_rd_data got=%h want=deadbeef", crd_l[2]); end
    total++; if (nstall !== 2) begin bad++;
      $display("FAIL cpu_rd_stall got=%0d want=2", nstall); end
  endtask

  task automatic test_dma_write();
    int nreq = 0, attr_bad = 0, ack_at = -1, cack_n = 0;
    wait_cfg = 3; rdata_cfg = 32'h0;
    dma_we = 1; dma_adr = 32'h40; dma_wd = 32'h1234; dma_req = 1;
    watch(8, 0, 0);
    for (int k = 0; k < 8; k++) begin
      if (mreq_l[k]) begin
        nreq++;
        if (madr_l[k] !== 32'h40 || mwe_l[k] !== 1'b1 || mwd_l[k] !== 32'h1234) attr_bad++;
      end
      if (dack_l[k] && ack_at < 0) ack_at = k;
      if (cack_l[k]) cack_n++;
    end
    total++; if (nreq !== 4) begin bad++;
      $display("FAIL dma_wr_memreq cycles=%0d want=4", nreq); end
    total++; if (attr_bad !== 0) begin bad++;
      $display("FAIL dma_wr_attr bad_cycles=%0d want=0", attr_bad); end
    total++; if (ack_at !== 5) begin bad++;
      $display("FAIL dma_wr_ack_cycle got=%0d want=5", ack_at); end
    total++; if (cack_n !== 0) begin bad++;
      $display("FAIL dma_wr_cpu_ack count=%0d want=0", cack_n); end
  endtask

  task automatic test_back_to_back();
    int c_at = -1, d_at = -1, both = 0;
    wait_cfg = 0; rdata_cfg = 32'h5A5A0000;
    cpu_we = 0; cpu_adr = 32'h100; cpu_req = 1;
    dma_we = 0; dma_adr = 32'h200; dma_req = 1;
    watch(8, 0, 0);
    for (int k = 0; k < 8; k++) begin
      if (cack_l[k] && c_at < 0) c_at = k;
      if (dack_l[k] && d_at < 0) d_at = k;
      if ((cack_l[k] && dack_l[k]) || (mreq_l[k] && (cack_l[k] || dack_l[k]))) both++;
    end
    total++; if (c_at !== 2 || d_at !== 5) begin bad++;
      $display("FAIL b2b_acks cpu=%0d dma=%0d want 2 and 5", c_at, d_at); end
    total++; if (mreq_l[1] !== 1'b1 || madr_l[1] !== 32'h100) begin bad++;
      $display("FAIL b2b_cpu_first req=%b adr=%h want 1/100", mreq_l[1], madr_l[1]); end
    total++; if (mreq_l[4] !== 1'b1 || madr_l[4] !== 32'h200) begin bad++;
      $display("FAIL b2b_dma_second req=%b adr=%h want 1/200", mreq_l[4], madr_l[4]); end
    total++; if (both !== 0) begin bad++;
      $display("FAIL b2b_overlap cycles=%0d want=0", both); end
  endtask

  task automatic test_starvation();
    int c_before = 0, d_at = -1;
    do_reset();
    wait_cfg = 0;
    cpu_we = 0; cpu_adr = 32'h10; cpu_req = 1;
    dma_we = 0; dma_adr = 32'h90; dma_req = 1;
    watch(16, 1, 0);
    for (int k = 0; k < 16; k++) begin
      if (dack_l[k] && d_at < 0) d_at = k;
      if (cack_l[k] && d_at < 0) c_before++;
    end
    total++; if (c_before !== 4) begin bad++;
      $display("FAIL starve_cpu_wins got=%0d want=4", c_before); end
    total++; if (d_at !== 14 || madr_l[13] !== 32'h90) begin bad++;
      $display("FAIL starve_dma_grant ack=%0d adr=%h want 14/90", d_at, madr_l[13]); end
    total++; if (sc_l[12] !== 4'd4) begin bad++;
      $display("FAIL starve_cnt_sat got=%0d want=4", sc_l[12]); end
    total++; if (sc_l[13] !== 4'd0) begin bad++;
      $display("FAIL starve_cnt_clear got=%0d want=0", sc_l[13]); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int cack_n = 0, ack_at = -1;
    wait_cfg = 10; rdata_cfg = 32'h0;
    cpu_we = 1; cpu_adr = 32'h80; cpu_wd = 32'h77; cpu_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; idle_inputs();
    total++; if ({mem_req, mem_we, cpu_ack, dma_ack} !== 4'b0 || mem_adr !== '0 ||
                 mem_wd !== '0) begin bad++;
      $display("FAIL rst_mid_outputs ctrl=%b adr=%h wd=%h want 0",
               {mem_req, mem_we, cpu_ack, dma_ack}, mem_adr, mem_wd); end
    watch(6, 0, 0);
    for (int k = 0; k < 6; k++) if (cack_l[k] || mreq_l[k]) cack_n++;
    total++; if (cack_n !== 0) begin bad++;
      $display("FAIL rst_mid_no_ack cycles=%0d want=0", cack_n); end
    wait_cfg = 0; rdata_cfg = 32'hCAFE0001;
    cpu_we = 0; cpu_adr = 32'h84; cpu_req = 1;
    watch(6, 0, 0);
    for (int k = 0; k < 6; k++) if (cack_l[k] && ack_at < 0) ack_at = k;
    total++; if (ack_at !== 2 || crd_l[2] !== 32'hCAFE0001) begin bad++;
      $display("FAIL rst_mid_fresh ack=%0d rd=%h want 2/cafe0001", ack_at, crd_l[2]); end
  endtask

  task automatic test_dma_adr_toggle();
    int adr_bad = 0, nreq = 0, c_at = -1, d_at = -1;
    wait_cfg = 2; rdata_cfg = 32'h0;
    cpu_we = 0; cpu_adr = 32'h300; cpu_req = 1;
    dma_we = 0; dma_req = 1;
    watch(12, 0, 1);
    for (int k = 0; k < 5; k++) begin
      if (mreq_l[k]) begin
        nreq++;
        if (madr_l[k] !== 32'h300) adr_bad++;
      end
    end
    for (int k = 0; k < 12; k++) begin
      if (cack_l[k] && c_at < 0) c_at = k;
      if (dack_l[k] && d_at < 0) d_at = k;
    end
    total++; if (nreq !== 3 || adr_bad !== 0) begin bad++;
      $display("FAIL toggle_cpu_adr cycles=%0d bad=%0d want 3/0", nreq, adr_bad); end
    total++; if (c_at !== 4 || d_at !== 9) begin bad++;
      $display("FAIL toggle_acks cpu=%0d dma=%0d want 4/9", c_at, d_at); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    test_dma_adr_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multicycle CPU and a DMA requester. The CPU has fixed priority, with a starvation guard that forces a DMA grant after `STARVE` consecutive contested CPU wins. The block sits between the datapath's memory port (`Adr`/`WriteData`/`ReadData`, qualified by the controller's `MemWrite`/`IRWrite` timing) and the memory, and exports `cpu_stall` so the controller FSM holds its state while an access is pending.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `STARVE`, 4, consecutive contested CPU grants before DMA is forced; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request; level, held until `cpu_ack`.
- `cpu_we`  in  1  CPU write enable; stable while `cpu_req` is high.
- `cpu_adr`  in  AW  CPU address.
- `cpu_wd`  in  DW  CPU write data.
- `cpu_rd`  out  DW  CPU read data; valid only while `cpu_ack` is high.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack` (combinational).
- `dma_req`, `dma_we`, `dma_adr`, `dma_wd`, `dma_rd`, `dma_ack`: same widths and rules as the CPU port.
- `mem_req`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  AW  memory address.
- `mem_wd`  out  DW  memory write data.
- `mem_rd`  in  DW  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion; sampled only while `mem_req` is high.

## Operation
- FSM states: `IDLE`, `GNT_CPU`, `GNT_DMA`, `ACK_CPU`, `ACK_DMA`.
- `IDLE`: if any request is pending, pick a winner, register `mem_we`/`mem_adr`/`mem_wd` from the winner, set `mem_req`=1, and go to `GNT_x`. Otherwise stay.
- Winner selection:
  - DMA wins if `dma_req & (~cpu_req | starve_cnt == STARVE)`.
  - Otherwise CPU wins.
- `starve_cnt` (4 bits):
  - increments on each CPU grant made while `dma_req` is high (saturates at `STARVE`);
  - clears on a DMA grant, and in any `IDLE` cycle with `dma_req` low.
- `GNT_x`: `mem_*` outputs are held constant. When `mem_ready` is high:
  - capture `mem_rd` into the read register;
  - drop `mem_req`;
  - go to `ACK_x`.
- `ACK_x`: `x_ack`=1 for exactly one cycle, and `x_rd` shows the captured data (writes capture too; the value is don't-care). Next state is always `IDLE`.
- Requester rule: after the edge ending the ack cycle, `x_req` is either low or a new request. Request inputs are not sampled outside `IDLE`.
- Changes to the loser's request or to the granted requester's inputs during `GNT`/`ACK` have no effect.

## Timing
- Reset values: state `IDLE`; `mem_req`, `mem_we`, `cpu_ack`, `dma_ack` = 0; `mem_adr`, `mem_wd`, `cpu_rd`, `dma_rd` = 0; `starve_cnt` = 0.
- Reset mid-transaction: abandon the access. `mem_req` is low in the cycle after the reset edge, and no ack is issued.
- Latency, request to ack:
  - request high in `IDLE` at cycle N;
  - `mem_req` high at N+1;
  - `mem_ready` at N+1+W (W ≥ 0 wait cycles);
  - ack at N+2+W.
  - Minimum 3 cycles per transaction. The back-to-back issue rate is one access per 3 cycles at W=0.
- `mem_req` is never high in `IDLE` or `ACK` states. The `mem_*` outputs come straight from registers (no combinational path from inputs).
- Simultaneous `cpu_req` and `dma_req` in `IDLE` with `starve_cnt < STARVE`: CPU wins. With `starve_cnt == STARVE`: DMA wins.
- `cpu_ack` and `dma_ack` are never high in the same cycle.

## Test plan
- Reset, then CPU read of `0x20`, memory returns `0xDEADBEEF` at W=0:
  - `mem_req` is high exactly 1 cycle with `mem_adr`=`0x20`, `mem_we`=0;
  - `cpu_ack`=1 with `cpu_rd`=`0xDEADBEEF` 2 cycles after request;
  - `cpu_stall` is high for 2 cycles.
- DMA write of `0x1234` to `0x40` with W=3:
  - `mem_req` is high 4 cycles, with `mem_we`=1 and `mem_wd`=`0x1234` constant throughout;
  - `dma_ack` comes 1 cycle after `mem_ready`;
  - `cpu_ack` stays 0.
- Simultaneous requests, counter 0: CPU is served first, then DMA. There is no gap other than the `IDLE` cycle, and the acks are 3 cycles apart at W=0.
- CPU requests continuously with `dma_req` held high, `STARVE`=4:
  - the first 4 grants go to CPU, the 5th goes to DMA;
  - `starve_cnt` returns to 0 after the DMA grant.
- Assert `reset` while in `GNT_CPU` with `mem_ready` low:
  - all outputs are 0 the next cycle;
  - no `cpu_ack` is ever issued for the dropped access;
  - a fresh CPU request then completes normally.
- Toggle `dma_adr` during a CPU grant: `mem_adr` keeps the CPU address for the whole grant.
